// File: rtl/wb_address_generator_pkg.sv
// Shared constants and FSM state type for the write-back address generator.
package wb_address_generator_pkg;

   localparam int BFU_NUM = 4;
   localparam int ADDR_W  = 10;
   localparam int CNT_W   = 7;
   localparam int BEATS   = 128;
   localparam int LANES   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } wb_state_e;

endpackage

// File: rtl/bit_rev.sv
// Pure combinational bit reversal: dout[i] = din[data_width-1-i].
module bit_rev #(
   parameter int data_width = 10
) (
   input  logic [data_width-1:0] din,
   output logic [data_width-1:0] dout
);

   for (genvar g = 0; g < data_width; g++) begin : g_bit
      assign dout[g] = din[data_width-1-g];
   end

endmodule

// File: rtl/wb_address_generator.sv
// Write-back address generator: one registered 8-lane address beat per accepted
// BFU result, with NTT/INTT layouts and optional bit reversal.
module wb_address_generator #(
   parameter int BEATS  = 128,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              ntt_flag,
   input  logic              rev,
   input  logic              in_valid,
   output logic [ADDR_W-1:0] new_address_0,
   output logic [ADDR_W-1:0] new_address_1,
   output logic [ADDR_W-1:0] new_address_2,
   output logic [ADDR_W-1:0] new_address_3,
   output logic [ADDR_W-1:0] new_address_4,
   output logic [ADDR_W-1:0] new_address_5,
   output logic [ADDR_W-1:0] new_address_6,
   output logic [ADDR_W-1:0] new_address_7,
   output logic              wr_en,
   output logic [6:0]        cnt_wb,
   output logic              busy,
   output logic              done
);

   import wb_address_generator_pkg::*;

   wb_state_e          r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_ntt;
   logic               r_rev;
   logic               r_wr_en;
   logic               r_busy;
   logic               r_done;
   logic [ADDR_W-1:0]  r_addr [LANES];

   logic [ADDR_W-1:0]  w_cnt_ext;
   logic [ADDR_W-1:0]  w_base_ntt;
   logic [ADDR_W-1:0]  w_base_intt;
   logic [ADDR_W-1:0]  w_base_hi;
   logic [ADDR_W-1:0]  w_lane [LANES];

   assign w_cnt_ext   = ADDR_W'(r_cnt);
   assign w_base_ntt  = w_cnt_ext << 3;
   assign w_base_intt = w_cnt_ext << 2;
   // INTT upper half lives in the top half of the address space.
   assign w_base_hi   = w_base_intt | (ADDR_W'(1) << (ADDR_W - 1));

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      logic [ADDR_W-1:0] w_lin;
      logic [ADDR_W-1:0] w_rev;

      always_comb begin
         if (!r_ntt) begin
            w_lin = w_base_ntt + ADDR_W'(g);
         end else if (g < 4) begin
            w_lin = w_base_intt + ADDR_W'(g);
         end else begin
            w_lin = w_base_hi + ADDR_W'(g - 4);
         end
      end

      bit_rev #(.data_width(ADDR_W)) u_bit_rev (
         .din  (w_lin),
         .dout (w_rev)
      );

      assign w_lane[g] = r_rev ? w_rev : w_lin;
   end

   // Stage FSM with registered outputs; wr_en/done default low each cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_ntt   <= 1'b0;
         r_rev   <= 1'b0;
         r_wr_en <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            r_addr[i] <= '0;
         end
      end else begin
         r_wr_en <= 1'b0;
         r_done  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_ntt   <= ntt_flag;
                  r_rev   <= rev;
               end
            end
            ST_RUN: begin
               if (in_valid) begin
                  r_wr_en <= 1'b1;
                  r_addr  <= w_lane;
                  if (r_cnt == CNT_W'(BEATS - 1)) begin
                     r_cnt   <= '0;
                     r_state <= ST_FLUSH;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            ST_FLUSH: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign new_address_0 = r_addr[0];
   assign new_address_1 = r_addr[1];
   assign new_address_2 = r_addr[2];
   assign new_address_3 = r_addr[3];
   assign new_address_4 = r_addr[4];
   assign new_address_5 = r_addr[5];
   assign new_address_6 = r_addr[6];
   assign new_address_7 = r_addr[7];
   assign wr_en         = r_wr_en;
   assign cnt_wb        = r_cnt;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_wb_address_generator.sv
// Directed self-checking bench for wb_address_generator with hand-computed vectors.
module tb_wb_address_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       ntt_flag = 1'b0;
   logic       rev = 1'b0;
   logic       in_valid = 1'b0;
   logic [9:0] a [8];
   logic       wr_en;
   logic [6:0] cnt_wb;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_err = 0;
   int n_wr  = 0;
   int n_done = 0;

   always #5 clk = ~clk;

   wb_address_generator #(.BEATS(128), .ADDR_W(10)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .ntt_flag      (ntt_flag),
      .rev           (rev),
      .in_valid      (in_valid),
      .new_address_0 (a[0]),
      .new_address_1 (a[1]),
      .new_address_2 (a[2]),
      .new_address_3 (a[3]),
      .new_address_4 (a[4]),
      .new_address_5 (a[5]),
      .new_address_6 (a[6]),
      .new_address_7 (a[7]),
      .wr_en         (wr_en),
      .cnt_wb        (cnt_wb),
      .busy          (busy),
      .done          (done)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_lanes(input string tag, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5, input int e6,
                              input int e7);
      int e [8];
      e = '{e0, e1, e2, e3, e4, e5, e6, e7};
      for (int i = 0; i < 8; i++) begin
         check_val($sformatf("%s_lane%0d", tag, i), int'(a[i]), e[i]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Start a stage and push n accepted beats.
   task automatic start_and_feed(input logic nf, input logic rv, input int n);
      ntt_flag = nf; rev = rv; start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < n; i++) step();
      in_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      step();
      step();
      check_val("rst_wr_en", int'(wr_en), 0);
      check_val("rst_busy", int'(busy), 0);
      check_val("rst_done", int'(done), 0);
      check_val("rst_cnt", int'(cnt_wb), 0);
      check_val("rst_addr0", int'(a[0]), 0);
      check_val("rst_addr7", int'(a[7]), 0);
      rst = 1'b0;

      // in_valid in IDLE is ignored
      in_valid = 1'b1;
      step();
      check_val("idle_ignore_wr", int'(wr_en), 0);
      in_valid = 1'b0;

      // NTT, rev=0, beat 5
      start_and_feed(1'b0, 1'b0, 5);
      check_val("ntt_busy", int'(busy), 1);
      check_val("ntt_cnt5", int'(cnt_wb), 5);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_val("ntt_wr", int'(wr_en), 1);
      check_lanes("ntt5", 40, 41, 42, 43, 44, 45, 46, 47);
      step();
      check_val("ntt_wr_low", int'(wr_en), 0);
      check_val("ntt_hold0", int'(a[0]), 40);
      check_val("ntt_hold7", int'(a[7]), 47);
      do_reset();

      // INTT, rev=0, beat 5
      start_and_feed(1'b1, 1'b0, 5);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check_val("intt_wr", int'(wr_en), 1);
      check_lanes("intt5", 20, 21, 22, 23, 532, 533, 534, 535);
      do_reset();

      // NTT, rev=1, beat 0
      start_and_feed(1'b0, 1'b1, 1);
      check_val("rev_wr", int'(wr_en), 1);
      check_lanes("rev0", 0, 512, 256, 768, 128, 640, 384, 896);
      check_val("rev_cnt1", int'(cnt_wb), 1);
      do_reset();

      // 128 back-to-back beats
      n_wr = 0; n_done = 0;
      ntt_flag = 1'b0; rev = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      for (int i = 1; i <= 128; i++) begin
         step();
         if (wr_en) n_wr++;
         if (done) n_done++;
         if (i == 64) check_val("full_busy_mid", int'(busy), 1);
      end
      check_val("full_done_last", int'(done), 1);
      check_val("full_wr_last", int'(wr_en), 1);
      check_val("full_busy_fell", int'(busy), 0);
      check_val("full_cnt_wrap", int'(cnt_wb), 0);
      check_lanes("full_last", 1016, 1017, 1018, 1019, 1020, 1021, 1022, 1023);
      // in_valid held through FLUSH and IDLE must be ignored
      for (int i = 0; i < 4; i++) begin
         step();
         if (wr_en) n_wr++;
         if (done) n_done++;
      end
      in_valid = 1'b0;
      check_val("full_wr_count", n_wr, 128);
      check_val("full_done_count", n_done, 1);
      check_val("full_idle_cnt", int'(cnt_wb), 0);
      check_val("full_idle_busy", int'(busy), 0);
      do_reset();

      // mid-stage flag changes and start during RUN have no effect
      start_and_feed(1'b0, 1'b0, 5);
      ntt_flag = 1'b1; rev = 1'b1; start = 1'b1; in_valid = 1'b1;
      step();
      start = 1'b0; in_valid = 1'b0;
      check_lanes("mid", 40, 41, 42, 43, 44, 45, 46, 47);
      check_val("mid_cnt", int'(cnt_wb), 6);
      do_reset();

      // reset at beat 60
      start_and_feed(1'b0, 1'b0, 60);
      check_val("abort_cnt60", int'(cnt_wb), 60);
      rst = 1'b1; in_valid = 1'b1; start = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0; start = 1'b0;
      check_val("abort_wr", int'(wr_en), 0);
      check_val("abort_cnt", int'(cnt_wb), 0);
      check_val("abort_busy", int'(busy), 0);
      check_val("abort_addr0", int'(a[0]), 0);
      n_done = 0;
      for (int i = 0; i < 3; i++) begin
         if (done) n_done++;
         step();
      end
      check_val("abort_no_done", n_done, 0);
      start_and_feed(1'b0, 1'b0, 1);
      check_val("restart_wr", int'(wr_en), 1);
      check_lanes("restart", 0, 1, 2, 3, 4, 5, 6, 7);
      check_val("restart_cnt", int'(cnt_wb), 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
